// File: rtl/arbiter_3rr.sv
// Three-way round-robin arbiter for a shared 3:1 mux path, with a bounded hold time per owner.
// One cycle from req to gnt; all outputs registered; waiting requesters are served within two hold windows.
module arbiter_3rr #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       busy
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_gnt,   w_gnt_nxt;
    logic [1:0] r_sel,   w_sel_nxt;
    logic [1:0] r_ptr,   w_ptr_nxt;
    logic [7:0] r_cnt,   w_cnt_nxt;
    logic       r_busy,  w_busy_nxt;

    logic       w_own_req;
    logic [2:0] w_others;
    logic [1:0] w_win_all;
    logic [1:0] w_win_oth;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // First requesting index scanning upward from last+1, modulo 3.
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] c0, c1, c2;
        c0 = next_idx(last);
        c1 = next_idx(c0);
        c2 = next_idx(c1);
        if (r[c0])      return c0;
        else if (r[c1]) return c1;
        else            return c2;
    endfunction

    assign w_own_req = |(req & r_gnt);
    assign w_others  = req & ~r_gnt;
    assign w_win_all = pick(req, r_ptr);
    assign w_win_oth = pick(w_others, r_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = 3'b001 << w_win_all;
                    w_sel_nxt   = w_win_all;
                    w_ptr_nxt   = w_win_all;
                    w_cnt_nxt   = 8'd1;
                    w_busy_nxt  = 1'b1;
                end
            end
            GRANT: begin
                if (req == 3'b000) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = 3'b000;
                    w_sel_nxt   = 2'b00;
                    w_cnt_nxt   = 8'd0;
                    w_busy_nxt  = 1'b0;
                end else if (!w_own_req || (r_cnt >= HOLD_LIM && |w_others)) begin
                    // Owner released or exhausted its window: hand over with no idle gap.
                    w_gnt_nxt = 3'b001 << w_win_oth;
                    w_sel_nxt = w_win_oth;
                    w_ptr_nxt = w_win_oth;
                    w_cnt_nxt = 8'd1;
                end else if (r_cnt < HOLD_LIM) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 3'b000;
                w_sel_nxt   = 2'b00;
                w_cnt_nxt   = 8'd0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= 3'b000;
            r_sel   <= 2'b00;
            r_ptr   <= 2'd2;
            r_cnt   <= 8'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;

endmodule

// File: tb/tb_arbiter_3rr.sv
// Bench for arbiter_3rr: directed scenarios on a HOLD_MAX=4 instance via an expected-grant queue,
// plus random invariant and starvation checks across HOLD_MAX 1, 4 and 255.
module tb_arbiter_3rr;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [2:0] gnt1, gnt4, gnt255;
    logic [1:0] sel1, sel4, sel255;
    logic       busy1, busy4, busy255;

    int checks = 0;
    int passed = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    arbiter_3rr #(.HOLD_MAX(4))   dut4   (.clk(clk), .reset(reset), .req(req), .gnt(gnt4),   .sel(sel4),   .busy(busy4));
    arbiter_3rr #(.HOLD_MAX(1))   dut1   (.clk(clk), .reset(reset), .req(req), .gnt(gnt1),   .sel(sel1),   .busy(busy1));
    arbiter_3rr #(.HOLD_MAX(255)) dut255 (.clk(clk), .reset(reset), .req(req), .gnt(gnt255), .sel(sel255), .busy(busy255));

    function automatic logic [1:0] sel_of(input logic [2:0] g);
        case (g)
            3'b010:  return 2'b01;
            3'b100:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Drive one cycle of req, queue the grant expected after the edge, then compare.
    task automatic cyc(input logic [2:0] r, input logic [2:0] eg, input string name);
        logic [2:0] e;
        req = r;
        exp_q.push_back(eg);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (gnt4 !== e) $display("FAIL %s gnt got %b want %b", name, gnt4, e);
        else passed++;
        checks++;
        if (sel4 !== sel_of(e)) $display("FAIL %s sel got %b want %b", name, sel4, sel_of(e));
        else passed++;
        checks++;
        if (busy4 !== (|e)) $display("FAIL %s busy got %b want %b", name, busy4, |e);
        else passed++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(3'b111, 3'b000, "reset0");
        cyc(3'b101, 3'b000, "reset1");
        reset = 1'b0;
    endtask

    task automatic test_single;
        test_reset();
        for (int i = 0; i < 3; i++) cyc(3'b001, 3'b001, "single");
        cyc(3'b000, 3'b000, "single_release");
    endtask

    task automatic test_rotation;
        logic [2:0] seq[4];
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
        test_reset();
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) cyc(3'b111, seq[k], "rotation");
        cyc(3'b000, 3'b000, "rotation_idle");
    endtask

    task automatic test_switch;
        test_reset();
        cyc(3'b011, 3'b001, "switch_own0");
        cyc(3'b011, 3'b001, "switch_own1");
        cyc(3'b010, 3'b010, "switch_direct");
        cyc(3'b000, 3'b000, "switch_idle");
    endtask

    task automatic test_lone_hold;
        test_reset();
        for (int i = 0; i < 10; i++) cyc(3'b100, 3'b100, "lone_hold");
        cyc(3'b110, 3'b010, "saturated_rotate");
        cyc(3'b000, 3'b000, "lone_idle");
    endtask

    task automatic test_back_to_back;
        test_reset();
        cyc(3'b001, 3'b001, "b2b_grant0");
        cyc(3'b011, 3'b001, "b2b_keep0");
        cyc(3'b010, 3'b010, "b2b_drop0");
        cyc(3'b011, 3'b010, "b2b_reassert0");
        cyc(3'b011, 3'b010, "b2b_hold1_3");
        cyc(3'b011, 3'b010, "b2b_hold1_4");
        cyc(3'b011, 3'b001, "b2b_rotate0");
        cyc(3'b000, 3'b000, "b2b_idle");
    endtask

    task automatic test_reset_mid;
        test_reset();
        cyc(3'b110, 3'b010, "mid_grant1");
        reset = 1'b1;
        cyc(3'b110, 3'b000, "mid_reset");
        reset = 1'b0;
        cyc(3'b110, 3'b010, "mid_after");
        cyc(3'b000, 3'b000, "mid_idle");
    endtask

    task automatic test_random;
        logic [2:0] r;
        logic [2:0] g[3];
        logic [1:0] s[3];
        logic       b[3];
        int         hm[3];
        int         wt[3][3];
        hm[0] = 1; hm[1] = 4; hm[2] = 255;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 3; i++) wt[d][i] = 0;
        r = 3'b000;
        test_reset();
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(15) == 0) r[i] = ~r[i];
            req = r;
            @(posedge clk);
            #1;
            g[0] = gnt1; g[1] = gnt4; g[2] = gnt255;
            s[0] = sel1; s[1] = sel4; s[2] = sel255;
            b[0] = busy1; b[1] = busy4; b[2] = busy255;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if ($countones(g[d]) > 1) $display("FAIL rand_onehot H=%0d gnt got %b want at most one bit", hm[d], g[d]);
                else passed++;
                checks++;
                if (s[d] !== sel_of(g[d])) $display("FAIL rand_sel H=%0d sel got %b want %b", hm[d], s[d], sel_of(g[d]));
                else passed++;
                checks++;
                if (b[d] !== (|g[d])) $display("FAIL rand_busy H=%0d busy got %b want %b", hm[d], b[d], |g[d]);
                else passed++;
                for (int i = 0; i < 3; i++) begin
                    if (r[i] && !g[d][i]) wt[d][i]++;
                    else wt[d][i] = 0;
                    checks++;
                    if (wt[d][i] > 2 * hm[d])
                        $display("FAIL rand_starve H=%0d req%0d waited %0d want <= %0d", hm[d], i, wt[d][i], 2 * hm[d]);
                    else passed++;
                end
            end
        end
        cyc(3'b000, 3'b000, "rand_idle");
    endtask

    initial begin
        reset = 1'b1;
        req   = 3'b000;
        test_reset();
        test_single();
        test_rotation();
        test_switch();
        test_lone_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/arbiter_3rr.md
ARBITER_3RR -- requirements
Module: arbiter_3rr

Interface
REQ-001 Parameter: HOLD_MAX, default 8, maximum consecutive grant cycles before forced rotation when others are waiting; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: req  input  3  request lines; req[i] high = requester i wants the shared 3:1 mux path.
REQ-005 Port: gnt  output  3  one-hot grant; gnt[i] high = requester i owns the path.
REQ-006 Port: sel  output  2  mux select for the 3:1 datapath mux; 2'b00 = din[0], 2'b01 = din[1], 2'b10 = din[2].
REQ-007 Port: busy  output  1  high while any grant is active.

Function
REQ-008 All outputs SHALL be driven directly from registers; no combinational path from req to gnt, sel or busy.
REQ-009 gnt SHALL be 3'b000 or exactly one bit high; sel SHALL never be 2'b11.
REQ-010 sel SHALL equal the index of the set gnt bit; when gnt = 3'b000, sel SHALL be 2'b00.
REQ-011 busy SHALL equal |gnt.
REQ-012 FSM states: IDLE (no owner) and GRANT (one owner).
REQ-013 A 2-bit last-owner pointer SHALL record the most recent owner; winner = first requesting index scanning from last+1 upward, modulo 3.
REQ-014 IDLE -> GRANT: when req != 3'b000 at an edge, that same edge SHALL load gnt/sel for the winner; latency one cycle from req sampled to gnt visible.
REQ-015 A 1-to-8-bit hold counter SHALL load 1 on every new grant, increment each cycle the owner is retained, and saturate at HOLD_MAX.
REQ-016 GRANT, req[owner] high, count < HOLD_MAX: keep the owner.
REQ-017 GRANT, req[owner] high, count == HOLD_MAX, another req bit high: at that edge rotate to the next winner (excluding the current owner); the owner thus holds exactly HOLD_MAX cycles.
REQ-018 GRANT, req[owner] high, count == HOLD_MAX, no other request: keep the owner; the counter stays at HOLD_MAX.
REQ-019 GRANT, req[owner] low, another req bit high: at that edge switch directly to the next winner with no idle cycle.
REQ-020 GRANT, req == 3'b000: return to IDLE at that edge; gnt = 3'b000, sel = 2'b00.
REQ-021 The pointer SHALL update to the new owner on every grant load; it SHALL be unchanged in IDLE.
REQ-022 A requester that drops and re-asserts req while another requester is waiting SHALL be served only after that requester.

Reset
REQ-023 While reset is high at an edge: state = IDLE, gnt = 3'b000, sel = 2'b00, busy = 0, count = 0, pointer = 2 (priority 0 > 1 > 2 on the next arbitration).
REQ-024 reset SHALL override every other input, including during an active grant; req is ignored on reset edges.
REQ-025 The first edge after reset deasserts SHALL arbitrate normally per REQ-014.

Verification (HOLD_MAX = 4 unless stated)
REQ-026 Reset, then req = 3'b001 for 3 cycles, then 3'b000 -> gnt = 001 and sel = 00 one cycle after req rises, held 3 cycles, then gnt = 000, busy = 0.
REQ-027 Reset, then req = 3'b111 held -> gnt sequence 001 x4, 010 x4, 100 x4, 001 x4; sel 00, 01, 10, 00.
REQ-028 gnt = 001 while req = 3'b011; drop req[0] after 2 cycles -> gnt = 010 at the next edge, no 000 cycle.
REQ-029 Only req[2] high for 10 cycles -> gnt = 100 and sel = 10 for all 10 cycles; no rotation.
REQ-030 Reset asserted while gnt = 010 and req = 3'b110 -> next edge gnt = 000, sel = 00, busy = 0; release reset -> gnt = 010 one cycle later (pointer reset to 2).
REQ-031 Random req for 10k cycles, HOLD_MAX in {1, 4, 255} -> one-hot gnt, sel never 11, sel matches gnt, no waiting requester starved longer than 2*HOLD_MAX cycles.
